// File: rtl/adder_pkg.sv
// Shared types and helpers for the registered CLA adder.
// Word width, flag bundle and the signed-overflow rule used by the top.
package adder_pkg;

  localparam int ADDER_WIDTH = 32;
  localparam int CLA_BITS    = 4;

  typedef logic [ADDER_WIDTH-1:0] word_t;

  typedef struct packed {
    logic carry;
    logic overflow;
  } flags_t;

  // Two's-complement overflow: like-signed operands giving an opposite-signed sum.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_if.sv
// Operand/result bundle between the adder and its producer/consumer.
// The master drives operands; the slave (the adder) returns the registered result.
interface adder_if #(parameter int WIDTH = adder_pkg::ADDER_WIDTH);

  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Q;
  logic             carry_out;
  logic             overflow;
  logic             out_valid;

  modport master (
    output in_valid, A, B,
    input  Q, carry_out, overflow, out_valid
  );

  modport slave (
    input  in_valid, A, B,
    output Q, carry_out, overflow, out_valid
  );

endinterface

// File: rtl/adder_cla4.sv
// 4-bit carry-lookahead group: internal carries computed in parallel,
// with group propagate/generate exported for the word-level chain.
module adder_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       p_grp,
  output logic       g_grp
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign p_grp = &p;
  assign g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign cout  = g_grp | (p_grp & cin);

  assign s = p ^ c;

endmodule

// File: rtl/adder.sv
// Registered WIDTH-bit adder: CLA groups rippling into each other, then a
// single output register stage with synchronous reset and a valid strobe.
module adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic   clk,
  input  logic   rst,
  adder_if.slave bus
);

  localparam int NG = WIDTH / CLA_BITS;

  logic [NG:0]      c;
  logic [NG-1:0]    cout;
  logic [NG-1:0]    p_grp;
  logic [NG-1:0]    g_grp;
  logic [WIDTH-1:0] sum;
  logic             pg_unused;
  flags_t           flags;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < NG; i++) begin : g_cla
    adder_cla4 u_cla (
      .a     (bus.A[CLA_BITS*i +: CLA_BITS]),
      .b     (bus.B[CLA_BITS*i +: CLA_BITS]),
      .cin   (c[i]),
      .s     (sum[CLA_BITS*i +: CLA_BITS]),
      .cout  (cout[i]),
      .p_grp (p_grp[i]),
      .g_grp (g_grp[i])
    );
    assign c[i+1] = cout[i];
  end

  // Group P/G are only needed if the chain is ever upgraded to a second lookahead level.
  assign pg_unused = ^{p_grp, g_grp};

  assign flags.carry    = c[NG];
  assign flags.overflow = signed_ovf(bus.A[WIDTH-1], bus.B[WIDTH-1], sum[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.Q         <= '0;
      bus.carry_out <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.Q         <= sum;
      bus.carry_out <= flags.carry;
      bus.overflow  <= flags.overflow;
      bus.out_valid <= bus.in_valid;
    end
  end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: directed table, reset sequences and a
// randomized stream checked against an arithmetic reference model.
module tb_adder;
  import adder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  adder_if #(.WIDTH(ADDER_WIDTH)) bus ();

  adder #(.WIDTH(ADDER_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    word_t a;
    word_t b;
    word_t q;
    logic  c;
    logic  o;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, then sample just after the next rising edge.
  task automatic apply(input logic r, input logic v, input word_t a, input word_t b);
    @(negedge clk);
    rst          = r;
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain wide-integer arithmetic, independent of the gate structure.
  task automatic model(input logic r, input logic v, input word_t a, input word_t b,
                       output word_t q, output logic c, output logic o, output logic vo);
    longint unsigned us;
    longint          ss;
    us = longint'(a) + longint'(b);
    ss = longint'($signed(a)) + longint'($signed(b));
    if (r) begin
      q = '0; c = 1'b0; o = 1'b0; vo = 1'b0;
    end else begin
      q  = us[31:0];
      c  = (us >= 64'h1_0000_0000);
      o  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      vo = v;
    end
  endtask

  task automatic step_check(input string tag, input logic r, input logic v, input word_t a, input word_t b);
    word_t eq;
    logic  ec, eo, ev;
    apply(r, v, a, b);
    model(r, v, a, b, eq, ec, eo, ev);
    check({tag, ".Q"},         bus.Q,                 eq);
    check({tag, ".carry_out"}, {31'b0, bus.carry_out}, {31'b0, ec});
    check({tag, ".overflow"},  {31'b0, bus.overflow},  {31'b0, eo});
    check({tag, ".out_valid"}, {31'b0, bus.out_valid}, {31'b0, ev});
  endtask

  initial begin
    vec_t  vecs[6];
    word_t ra, rb;
    logic  rv, rr;

    bus.in_valid = 1'b0;
    bus.A        = '0;
    bus.B        = '0;

    vecs[0] = '{a: 32'd1,          b: 32'd2,          q: 32'd3,          c: 1'b0, o: 1'b0};
    vecs[1] = '{a: 32'd15499,      b: 32'd1,          q: 32'd15500,      c: 1'b0, o: 1'b0};
    vecs[2] = '{a: 32'd120000,     b: 32'd240000,     q: 32'd360000,     c: 1'b0, o: 1'b0};
    vecs[3] = '{a: 32'h4000_0000,  b: 32'h4000_0000,  q: 32'h8000_0000,  c: 1'b0, o: 1'b1};
    vecs[4] = '{a: 32'hFFFF_FFFF,  b: 32'h0000_0001,  q: 32'h0000_0000,  c: 1'b1, o: 1'b0};
    vecs[5] = '{a: 32'h8000_0000,  b: 32'h8000_0000,  q: 32'h0000_0000,  c: 1'b1, o: 1'b1};

    // Reset held two cycles with a valid sample present: reset must win.
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b1, 32'd5, 32'd7);
      check("rst.Q",         bus.Q,                  32'd0);
      check("rst.carry_out", {31'b0, bus.carry_out}, 32'd0);
      check("rst.overflow",  {31'b0, bus.overflow},  32'd0);
      check("rst.out_valid", {31'b0, bus.out_valid}, 32'd0);
    end
    apply(1'b0, 1'b1, 32'd5, 32'd7);
    check("post_rst.Q",         bus.Q,                  32'd12);
    check("post_rst.out_valid", {31'b0, bus.out_valid}, 32'd1);

    foreach (vecs[i]) begin
      apply(1'b0, 1'b1, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d.Q", i),         bus.Q,                  vecs[i].q);
      check($sformatf("vec%0d.carry_out", i), {31'b0, bus.carry_out}, {31'b0, vecs[i].c});
      check($sformatf("vec%0d.overflow", i),  {31'b0, bus.overflow},  {31'b0, vecs[i].o});
      check($sformatf("vec%0d.out_valid", i), {31'b0, bus.out_valid}, 32'd1);
    end

    // Registers load even without in_valid; only the strobe stays low.
    apply(1'b0, 1'b0, 32'd3, 32'd4);
    check("novalid.Q",         bus.Q,                  32'd7);
    check("novalid.out_valid", {31'b0, bus.out_valid}, 32'd0);

    // Mid-stream reset: one valid result in flight, flushed, then recovery.
    step_check("flush_pre",  1'b0, 1'b1, 32'hDEAD_BEEF, 32'h1111_1111);
    step_check("flush_rst",  1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001);
    step_check("flush_post", 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001);

    for (int i = 0; i < 1000; i++) begin
      ra = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom();
      rb = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom();
      rv = 1'($urandom_range(0, 1));
      rr = (i == 500);
      step_check($sformatf("rand%0d", i), rr, rv, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
